// File: rtl/gpu_clut_loader_if.sv
// Memory read port plus CLUT cache write port of the CLUT loader.
// Latency: none, this is a bundle of wires.
// Backpressure: i_memAck holds the request, i_memDataValid paces each beat.
interface gpu_clut_loader_if;
  // memory arbiter read port
  logic        o_memReq;
  logic [14:0] o_memAdr;
  logic        i_memAck;
  logic        i_memDataValid;
  logic [31:0] i_memData;
  // CLUT cache write port
  logic        o_clutWrite;
  logic [6:0]  o_clutWrAdr;
  logic [31:0] o_clutWrData;

  // loader side
  modport master (
    output o_memReq,
    output o_memAdr,
    input  i_memAck,
    input  i_memDataValid,
    input  i_memData,
    output o_clutWrite,
    output o_clutWrAdr,
    output o_clutWrData
  );

  // memory / cache side
  modport slave (
    input  o_memReq,
    input  o_memAdr,
    output i_memAck,
    output i_memDataValid,
    output i_memData,
    input  o_clutWrite,
    input  o_clutWrAdr,
    input  o_clutWrData
  );
endinterface

// File: rtl/gpu_clut_loader.sv
// Fetches 16-entry CLUT packets (8 x 32-bit beats) from VRAM into the CLUT cache.
// Latency: request the cycle after start, write same cycle as beat, 11 cycles/packet min.
// Backpressure: request held until ack, beats may be gapped, load never aborts mid-packet.
module gpu_clut_loader (
  input  logic              i_clk,
  input  logic              i_nRstGPU,
  input  logic              i_loadActive,
  input  logic              i_stillRemainingClutPacket,
  input  logic [14:0]       i_adrClutCacheUpdate,
  input  logic [3:0]        i_currentClutBlock,
  output logic              o_decClutCount,
  output logic              o_endClutLoading,
  output logic              o_busy,
  gpu_clut_loader_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_DEC  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [2:0]  beat_q,  beat_d;
  logic [14:0] adr_q,   adr_d;
  logic [3:0]  block_q, block_d;

  logic start_load;
  logic beat_wr;

  // a new packet is started whenever the manager still has one pending
  assign start_load = (state_q == S_IDLE) && i_loadActive && i_stillRemainingClutPacket;
  // only beats that arrive while collecting data reach the cache
  assign beat_wr    = (state_q == S_DATA) && bus.i_memDataValid;

  // next-state logic; the manager count minus one selects the cache block,
  // so count 16 (low bits 0) maps to block 15 and count 1 to block 0
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    adr_d   = adr_q;
    block_d = block_q;
    case (state_q)
      S_IDLE: begin
        if (start_load) begin
          adr_d   = i_adrClutCacheUpdate;
          block_d = i_currentClutBlock - 4'd1;
          state_d = S_REQ;
        end else if (i_loadActive) begin
          state_d = S_DONE;
        end
      end
      S_REQ: begin
        if (bus.i_memAck) begin
          beat_d  = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.i_memDataValid) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            state_d = S_DEC;
          end
        end
      end
      // manager decrements its count on this edge, IDLE then sees the new value
      S_DEC:   state_d = S_IDLE;
      // gives the manager one cycle to drop its loading flag
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_nRstGPU) begin
      state_q <= S_IDLE;
      beat_q  <= 3'd0;
      adr_q   <= 15'd0;
      block_q <= 4'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      adr_q   <= adr_d;
      block_q <= block_d;
    end
  end

  // handshake outputs decoded from the current state
  assign bus.o_memReq     = (state_q == S_REQ);
  assign bus.o_memAdr     = adr_q;
  assign o_decClutCount   = (state_q == S_DEC);
  assign o_endClutLoading = (state_q == S_IDLE) && i_loadActive && !i_stillRemainingClutPacket;
  assign o_busy           = (state_q != S_IDLE);

  // cache write is combinational from the beat; data is zeroed when not writing
  assign bus.o_clutWrite  = beat_wr;
  assign bus.o_clutWrAdr  = {block_q, beat_q};
  assign bus.o_clutWrData = beat_wr ? bus.i_memData : 32'd0;

endmodule

// File: tb/tb_gpu_clut_loader.sv
// Directed bench for gpu_clut_loader: 4bpp, 8bpp, backpressure, gaps, reset, load drop.
module tb_gpu_clut_loader;

  logic        i_clk;
  logic        i_nRstGPU;
  logic        i_loadActive;
  logic        i_stillRemainingClutPacket;
  logic [14:0] i_adrClutCacheUpdate;
  logic [3:0]  i_currentClutBlock;
  logic        o_decClutCount;
  logic        o_endClutLoading;
  logic        o_busy;

  gpu_clut_loader_if bus ();

  gpu_clut_loader dut (
    .i_clk                      (i_clk),
    .i_nRstGPU                  (i_nRstGPU),
    .i_loadActive               (i_loadActive),
    .i_stillRemainingClutPacket (i_stillRemainingClutPacket),
    .i_adrClutCacheUpdate       (i_adrClutCacheUpdate),
    .i_currentClutBlock         (i_currentClutBlock),
    .o_decClutCount             (o_decClutCount),
    .o_endClutLoading           (o_endClutLoading),
    .o_busy                     (o_busy),
    .bus                        (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_wr   = 0;
  int n_dec  = 0;
  int n_end  = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // count strobes mid-cycle, well away from the rising edge
  always @(negedge i_clk) begin
    if (i_nRstGPU && bus.o_clutWrite)    n_wr++;
    if (i_nRstGPU && o_decClutCount)     n_dec++;
    if (i_nRstGPU && o_endClutLoading)   n_end++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] beat_data(input logic [14:0] adr, input logic [2:0] b);
    return {1'b0, adr, 13'h0A5, b};
  endfunction

  // One packet starting in an IDLE cycle; returns positioned at the following IDLE
  // cycle, where the caller must present the manager's updated inputs.
  task automatic packet(input logic [14:0] adr, input logic [3:0] cnt, input logic [3:0] exp_blk,
                        input int ack_dly, input bit gap, input bit spur, input bit drop);
    int wr0;
    wr0 = n_wr;
    i_loadActive = 1'b1;
    i_stillRemainingClutPacket = 1'b1;
    i_adrClutCacheUpdate = adr;
    i_currentClutBlock = cnt;
    settle();
    check("idle_req", bus.o_memReq, 0);
    check("idle_busy", o_busy, 0);
    check("idle_end", o_endClutLoading, 0);
    cyc();
    for (int i = 0; i < ack_dly; i++) begin
      bus.i_memAck = 1'b0;
      bus.i_memDataValid = 1'b0;
      settle();
      check("wait_req", bus.o_memReq, 1);
      check("wait_adr", bus.o_memAdr, {17'd0, adr});
      check("wait_wr", bus.o_clutWrite, 0);
      cyc();
    end
    bus.i_memAck = 1'b1;
    bus.i_memDataValid = spur;
    bus.i_memData = 32'hDEADBEEF;
    settle();
    check("ack_req", bus.o_memReq, 1);
    check("ack_adr", bus.o_memAdr, {17'd0, adr});
    check("ack_wr", bus.o_clutWrite, 0);
    cyc();
    bus.i_memAck = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (gap && b > 0) begin
        bus.i_memDataValid = 1'b0;
        settle();
        check("gap_wr", bus.o_clutWrite, 0);
        cyc();
      end
      if (drop && b == 3) i_loadActive = 1'b0;
      bus.i_memDataValid = 1'b1;
      bus.i_memData = beat_data(adr, b[2:0]);
      settle();
      check("beat_req", bus.o_memReq, 0);
      check("beat_wr", bus.o_clutWrite, 1);
      check("beat_wradr", bus.o_clutWrAdr, {25'd0, exp_blk, b[2:0]});
      check("beat_wrdat", bus.o_clutWrData, beat_data(adr, b[2:0]));
      check("beat_dec", o_decClutCount, 0);
      cyc();
    end
    bus.i_memDataValid = 1'b0;
    settle();
    check("dec_pulse", o_decClutCount, 1);
    check("dec_end", o_endClutLoading, 0);
    check("dec_wrcnt", n_wr - wr0, 8);
    cyc();
  endtask

  initial begin
    int dec0;
    int end0;
    i_nRstGPU = 1'b0;
    i_loadActive = 1'b0;
    i_stillRemainingClutPacket = 1'b0;
    i_adrClutCacheUpdate = 15'd0;
    i_currentClutBlock = 4'd0;
    bus.i_memAck = 1'b0;
    bus.i_memDataValid = 1'b0;
    bus.i_memData = 32'd0;
    cyc();
    cyc();
    i_nRstGPU = 1'b1;
    settle();
    check("rst_req", bus.o_memReq, 0);
    check("rst_adr", bus.o_memAdr, 0);
    check("rst_wr", bus.o_clutWrite, 0);
    check("rst_wradr", bus.o_clutWrAdr, 0);
    check("rst_dec", o_decClutCount, 0);
    check("rst_end", o_endClutLoading, 0);
    check("rst_busy", o_busy, 0);

    // 4bpp: single packet, block 0, then end of load
    dec0 = n_dec;
    end0 = n_end;
    packet(15'h0A43, 4'd1, 4'd0, 0, 1'b0, 1'b0, 1'b0);
    i_stillRemainingClutPacket = 1'b0;
    settle();
    check("4b_end", o_endClutLoading, 1);
    check("4b_end_busy", o_busy, 0);
    cyc();
    check("4b_done_busy", o_busy, 1);
    check("4b_done_end", o_endClutLoading, 0);
    check("4b_done_req", bus.o_memReq, 0);
    i_loadActive = 1'b0;
    cyc();
    settle();
    check("4b_idle_busy", o_busy, 0);
    check("4b_ndec", n_dec - dec0, 1);
    check("4b_nend", n_end - end0, 1);

    // 8bpp: manager count 16..1, X offsets 0x1F..0x10, blocks 15..0
    dec0 = n_dec;
    end0 = n_end;
    for (int c = 16; c >= 1; c--) begin
      logic [14:0] a;
      logic [3:0]  cl;
      a  = {9'd5, 6'(6'h10 + c - 1)};
      cl = 4'(c);
      packet(a, cl, 4'(c - 1), 0, 1'b0, 1'b0, 1'b0);
    end
    i_stillRemainingClutPacket = 1'b0;
    settle();
    check("8b_end", o_endClutLoading, 1);
    cyc();
    i_loadActive = 1'b0;
    cyc();
    settle();
    check("8b_idle_busy", o_busy, 0);
    check("8b_ndec", n_dec - dec0, 16);
    check("8b_nend", n_end - end0, 1);

    // backpressure: ack after 5 wait cycles -> request high 6 cycles
    packet(15'h7FC1, 4'd7, 4'd6, 5, 1'b0, 1'b0, 1'b0);
    i_loadActive = 1'b0;
    i_stillRemainingClutPacket = 1'b0;
    cyc();

    // gapped beats plus a spurious valid in the ack cycle
    packet(15'h2222, 4'd0, 4'd15, 1, 1'b1, 1'b1, 1'b0);
    i_loadActive = 1'b0;
    i_stillRemainingClutPacket = 1'b0;
    cyc();

    // reset during beat 4, then a fresh load restarts at beat 0
    i_loadActive = 1'b1;
    i_stillRemainingClutPacket = 1'b1;
    i_adrClutCacheUpdate = 15'h0777;
    i_currentClutBlock = 4'd9;
    cyc();
    bus.i_memAck = 1'b1;
    cyc();
    bus.i_memAck = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.i_memDataValid = 1'b1;
      bus.i_memData = beat_data(15'h0777, b[2:0]);
      settle();
      check("prerst_wradr", bus.o_clutWrAdr, {25'd0, 4'd8, b[2:0]});
      cyc();
    end
    bus.i_memDataValid = 1'b1;
    i_nRstGPU = 1'b0;
    cyc();
    i_nRstGPU = 1'b1;
    bus.i_memDataValid = 1'b0;
    i_loadActive = 1'b0;
    i_stillRemainingClutPacket = 1'b0;
    settle();
    check("mrst_req", bus.o_memReq, 0);
    check("mrst_adr", bus.o_memAdr, 0);
    check("mrst_wr", bus.o_clutWrite, 0);
    check("mrst_wradr", bus.o_clutWrAdr, 0);
    check("mrst_wrdat", bus.o_clutWrData, 0);
    check("mrst_dec", o_decClutCount, 0);
    check("mrst_busy", o_busy, 0);
    cyc();
    packet(15'h1234, 4'd3, 4'd2, 0, 1'b0, 1'b0, 1'b0);
    i_loadActive = 1'b0;
    i_stillRemainingClutPacket = 1'b0;
    cyc();

    // load flag dropped during data: packet completes, nothing new starts
    dec0 = n_dec;
    packet(15'h4D5A, 4'd12, 4'd11, 0, 1'b0, 1'b0, 1'b1);
    i_loadActive = 1'b0;
    i_stillRemainingClutPacket = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("drop_req", bus.o_memReq, 0);
      check("drop_busy", o_busy, 0);
      cyc();
    end
    check("drop_ndec", n_dec - dec0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
